// File: rtl/right_logic_shifter.sv
// Registered logical right shifter: a log2-stage barrel network feeding one output flop.
// Amounts of N or more force the result to zero instead of relying on the barrel stages.
module right_logic_shifter #(
   parameter int N  = 4,
   parameter int SW = $clog2(N) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  a,
   input  logic [SW-1:0] shift,
   output logic [N-1:0]  y
);

   localparam int          L    = $clog2(N);
   localparam logic [SW-1:0] N_SW = SW'(N);

   logic [L:0][N-1:0] stage_s;
   logic              over_s;
   logic [N-1:0]      y_d;
   logic [N-1:0]      y_q;

   // Barrel stages: stage i moves the word down by 2^i when shift[i] is set.
   always_comb begin
      stage_s[0] = a;
      for (int i = 0; i < L; i++) begin
         if (shift[i]) begin
            stage_s[i+1] = stage_s[i] >> (1 << i);
         end else begin
            stage_s[i+1] = stage_s[i];
         end
      end
   end

   // Zero-force for out-of-range amounts, else take the last barrel stage.
   always_comb begin
      over_s = (shift >= N_SW);
      if (over_s) begin
         y_d = {N{1'b0}};
      end else begin
         y_d = stage_s[L];
      end
   end

   // Output register; synchronous reset wins over the sampled operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q <= {N{1'b0}};
      end else begin
         y_q <= y_d;
      end
   end

   assign y = y_q;

endmodule

// File: tb/tb_right_logic_shifter.sv
// Scoreboard bench for right_logic_shifter: a driver pushes expected results from an
// arithmetic reference model, and a monitor pops and compares one result per clock edge.
module tb_right_logic_shifter;

   localparam int N  = 4;
   localparam int SW = $clog2(N) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  a;
   logic [SW-1:0] shift;
   logic [N-1:0]  y;

   logic [N-1:0] exp_q [$];
   int n_checks = 0;
   int n_pass   = 0;

   right_logic_shifter #(.N(N), .SW(SW)) dut (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .shift (shift),
      .y     (y)
   );

   always #5 clk = ~clk;

   // Reference: divide by 2^shift, zero when shift reaches the width or reset is high.
   function automatic logic [N-1:0] ref_model(input logic r, input int unsigned av,
                                              input int unsigned sv);
      if (r) return '0;
      if (sv >= N) return '0;
      return N'(av / (32'd1 << sv));
   endfunction

   task automatic drive(input logic r, input logic [N-1:0] av, input logic [SW-1:0] sv);
      @(negedge clk);
      rst   = r;
      a     = av;
      shift = sv;
      exp_q.push_back(ref_model(r, int'(av), int'(sv)));
   endtask

   // Monitor: the DUT presents one result per edge for every sample pushed before it.
   initial begin
      logic [N-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (y === e) n_pass++;
            else $display("FAIL y_check t=%0t: y=%b expected %b", $time, y, e);
         end
      end
   end

   logic [N-1:0] sweep_a [15];

   initial begin
      int budget;
      sweep_a = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100, 4'b0110, 4'b0011, 4'b1001,
                  4'b1010, 4'b0101, 4'b1110, 4'b1101, 4'b1011, 4'b1111, 4'b0000};
      rst   = 1'b1;
      a     = '0;
      shift = '0;

      drive(1'b1, 4'b1111, 3'd1);
      for (int i = 0; i < 15; i++) drive(1'b0, sweep_a[i], 3'd1);
      for (int i = 0; i < 14; i++) drive(1'b0, sweep_a[i], 3'd2);
      drive(1'b0, 4'b1111, 3'd0);
      drive(1'b0, 4'b1111, 3'd3);
      drive(1'b0, 4'b1111, 3'd4);
      drive(1'b0, 4'b1111, 3'd7);

      for (int i = 0; i < 200; i++)
         drive(1'b0, N'($urandom_range(0, 15)), SW'($urandom_range(0, 7)));

      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 10; i++)
            drive(1'b0, N'($urandom_range(0, 15)), SW'($urandom_range(0, 7)));
         drive(1'b1, N'($urandom_range(1, 15)), SW'($urandom_range(0, 2)));
         for (int i = 0; i < 10; i++)
            drive(1'b0, N'($urandom_range(0, 15)), SW'($urandom_range(0, 7)));
      end

      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      #2;
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
